// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states and logic-unit select encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StExec,
    StSendHi,
    StSendLo
  } state_e;

  localparam logic [1:0] SEL_AND_NAND = 2'b00;
  localparam logic [1:0] SEL_OR_NOR   = 2'b01;
  localparam logic [1:0] SEL_XOR_XNOR = 2'b10;
  localparam logic [1:0] SEL_NOT      = 2'b11;

endpackage

// File: rtl/logic_unit.sv
// Combinational 16-bit logic unit: high half carries the primary function,
// low half its complement (or NOT op2 for the NOT select).
module logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] logic_in,
  input  logic [1:0]         logic_lines,
  output logic [2*WIDTH-1:0] logic_out
);

  logic [WIDTH-1:0] a, b, f;

  assign a = logic_in[2*WIDTH-1:WIDTH];
  assign b = logic_in[WIDTH-1:0];

  always_comb begin
    f = '0;
    logic_out = '0;
    unique case (logic_lines)
      SEL_AND_NAND: f = a & b;
      SEL_OR_NOR:   f = a | b;
      SEL_XOR_XNOR: f = a ^ b;
      SEL_NOT:      f = ~a;
      default:      f = '0;
    endcase
    logic_out = (logic_lines == SEL_NOT) ? {~a, ~b} : {f, ~f};
  end

endmodule

// File: rtl/logic_sequencer.sv
// Collects two operands plus a select from a 16-bit stream, drives logic_unit,
// and returns the registered 32-bit result as two 16-bit beats.
module logic_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] logic_in,
  output logic [1:0]         logic_lines,
  input  logic [2*WIDTH-1:0] logic_out,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [1:0]         sel_q, sel_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoadA;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sel_d   = sel_q;
    res_d   = res_q;
    case (state_q)
      StLoadA: begin
        if (in_valid) begin
          op1_d   = in_data;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        if (in_valid) begin
          op2_d   = in_data;
          sel_d   = in_sel;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = logic_out;
        state_d = StSendHi;
      end
      StSendHi: if (out_ready) state_d = StSendLo;
      StSendLo: if (out_ready) state_d = StLoadA;
      default:  state_d = StLoadA;
    endcase
  end

  // Outputs decode the state only; rst forces the idle/zero view while asserted.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    busy        = 1'b0;
    logic_in    = '0;
    logic_lines = '0;
    if (!rst) begin
      logic_in    = {op1_q, op2_q};
      logic_lines = sel_q;
      busy        = (state_q != StLoadA);
      case (state_q)
        StLoadA, StLoadB: in_ready = 1'b1;
        StSendHi: begin
          out_valid = 1'b1;
          out_data  = res_q[2*WIDTH-1:WIDTH];
        end
        StSendLo: begin
          out_valid = 1'b1;
          out_last  = 1'b1;
          out_data  = res_q[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_sequencer.sv
// Directed bench for logic_sequencer paired with logic_unit.
module tb_logic_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] logic_in;
  logic [1:0]  logic_lines;
  logic [31:0] logic_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_sequencer #(.WIDTH(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .logic_in   (logic_in),
    .logic_lines(logic_lines),
    .logic_out  (logic_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  logic_unit #(.WIDTH(16)) u_lu (
    .logic_in   (logic_in),
    .logic_lines(logic_lines),
    .logic_out  (logic_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with out_ready held high; checks latency and both beats.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                        input logic [15:0] hi, input logic [15:0] lo);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = a;
    in_sel    = ~sel;
    tick();
    in_data = b;
    in_sel  = sel;
    tick();
    in_valid = 1'b0;
    check("exec_valid", {31'd0, out_valid}, 32'd0);
    check("exec_ready", {31'd0, in_ready}, 32'd0);
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("logic_in", logic_in, {a, b});
    check("logic_lines", {30'd0, logic_lines}, {30'd0, sel});
    tick();
    check("hi_valid", {31'd0, out_valid}, 32'd1);
    check("hi_data", {16'd0, out_data}, {16'd0, hi});
    check("hi_last", {31'd0, out_last}, 32'd0);
    tick();
    check("lo_valid", {31'd0, out_valid}, 32'd1);
    check("lo_data", {16'd0, out_data}, {16'd0, lo});
    check("lo_last", {31'd0, out_last}, 32'd1);
    tick();
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0;
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_logic_in", logic_in, 32'd0);
    check("rst_lines", {30'd0, logic_lines}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    run_op(16'hF0F0, 16'hFF00, 2'b00, 16'hF000, 16'h0FFF);
    run_op(16'hF0F0, 16'hFF00, 2'b01, 16'hFFF0, 16'h000F);
    run_op(16'hF0F0, 16'hFF00, 2'b10, 16'h0FF0, 16'hF00F);
    run_op(16'hF0F0, 16'hFF00, 2'b11, 16'h0F0F, 16'h00FF);

    // Output stall in SEND_HI.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hF0F0;
    tick();
    in_data = 16'hFF00; in_sel = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("stall_data", {16'd0, out_data}, 32'h0000_F000);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_last", {31'd0, out_last}, 32'd0);
      tick();
    end
    check("stall_hold", {16'd0, out_data}, 32'h0000_F000);
    out_ready = 1'b1;
    tick();
    check("stall_lo", {16'd0, out_data}, 32'h0000_0FFF);
    check("stall_lo_last", {31'd0, out_last}, 32'd1);
    tick();

    // Continuous input: third beat must wait for LOAD_A.
    in_valid = 1'b1; in_data = 16'h1111; in_sel = 2'b11;
    tick();
    in_data = 16'h2222; in_sel = 2'b01;
    tick();
    in_data = 16'h3333; in_sel = 2'b00;
    check("cont_logic_in", logic_in, 32'h1111_2222);
    tick();
    check("cont_hi_ready", {31'd0, in_ready}, 32'd0);
    check("cont_hi", {16'd0, out_data}, 32'h0000_3333);
    tick();
    check("cont_lo", {16'd0, out_data}, 32'h0000_CCCC);
    check("cont_lo_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("cont_back_ready", {31'd0, in_ready}, 32'd1);
    check("cont_not_taken", logic_in, 32'h1111_2222);
    tick();
    check("cont_taken", {16'd0, logic_in[31:16]}, 32'h0000_3333);
    check("cont_busy", {31'd0, busy}, 32'd1);
    in_data = 16'h000F; in_sel = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    check("cont2_hi", {16'd0, out_data}, 32'h0000_0003);
    tick();
    check("cont2_lo", {16'd0, out_data}, 32'h0000_FFFC);
    tick();

    // Reset in SEND_HI discards the pending result.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hF0F0;
    tick();
    in_data = 16'hFF00; in_sel = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {16'd0, out_data}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_logic_in", logic_in, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_lo_beat", {31'd0, out_valid}, 32'd0);
    end

    // Reset in LOAD_B discards op1, and wins over in_valid.
    in_valid = 1'b1; in_data = 16'hAAAA; in_sel = 2'b00;
    tick();
    check("loadb_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; in_data = 16'h5555;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("loadb_rst_in", logic_in, 32'd0);
    check("loadb_rst_busy", {31'd0, busy}, 32'd0);
    run_op(16'h0001, 16'h0003, 2'b10, 16'h0002, 16'hFFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
